// File: rtl/riscv_core_ahb_arbiter.sv
// Two-requester AHB-Lite arbiter: instruction fetch (IF) and load/store (LS)
// share one master port. LS has priority, bounded by a fetch starvation counter.
module riscv_core_ahb_arbiter #(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_write,
  input  logic [2:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int unsigned CW = 4;
  localparam logic [2:0]  SIZE_WORD = 3'b010;
  localparam logic [1:0]  TRANS_IDLE = 2'b00;
  localparam logic [1:0]  TRANS_NONSEQ = 2'b10;

  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  // Address-phase slot
  logic        a_valid;
  owner_e      a_owner;
  logic [31:0] a_addr;
  logic        a_write;
  logic [2:0]  a_size;
  logic [31:0] a_wdata;

  // Data-phase slot; wdata is zeroed for reads so it drives HWDATA directly
  logic        d_valid;
  owner_e      d_owner;
  logic [31:0] d_wdata;

  logic [CW-1:0] starve;

  logic advance_c;
  logic pick_ls_c;
  logic pick_if_c;
  logic complete_c;

  // Arbitration: LS wins unless IF has been passed over MAX_STARVE times
  always_comb begin
    advance_c  = !a_valid || HREADY;
    pick_ls_c  = ls_req && (!if_req || (starve < CW'(MAX_STARVE)));
    pick_if_c  = if_req && !pick_ls_c;
    if_gnt     = RST && advance_c && pick_if_c;
    ls_gnt     = RST && advance_c && pick_ls_c;
    complete_c = RST && d_valid && HREADY;
  end

  // Fetch starvation counter, saturating at MAX_STARVE
  always_ff @(posedge CLK) begin
    if (!RST) begin
      starve <= '0;
    end else if (if_gnt || !if_req) begin
      starve <= '0;
    end else if (ls_gnt && (starve != CW'(MAX_STARVE))) begin
      starve <= starve + CW'(1);
    end
  end

  // Address slot loads the winner (or empties) whenever the bus can advance
  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_valid <= 1'b0;
      a_owner <= OWN_IF;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_size  <= '0;
      a_wdata <= '0;
    end else if (advance_c) begin
      a_valid <= if_gnt || ls_gnt;
      a_owner <= ls_gnt ? OWN_LS : OWN_IF;
      a_addr  <= ls_gnt ? ls_addr : (if_gnt ? if_addr : 32'h0);
      a_write <= ls_gnt && ls_write;
      a_size  <= ls_gnt ? ls_size : (if_gnt ? SIZE_WORD : 3'b000);
      a_wdata <= ls_gnt ? ls_wdata : 32'h0;
    end
  end

  // Data slot follows the address slot only on HREADY, so wait states hold it
  always_ff @(posedge CLK) begin
    if (!RST) begin
      d_valid <= 1'b0;
      d_owner <= OWN_IF;
      d_wdata <= '0;
    end else if (HREADY) begin
      d_valid <= a_valid;
      d_owner <= a_owner;
      d_wdata <= (a_valid && a_write) ? a_wdata : 32'h0;
    end
  end

  // Bus drive and response routing
  always_comb begin
    HTRANS    = a_valid ? TRANS_NONSEQ : TRANS_IDLE;
    HADDR     = a_addr;
    HWRITE    = a_write;
    HSIZE     = a_size;
    HWDATA    = d_wdata;
    if_rvalid = complete_c && (d_owner == OWN_IF);
    ls_rvalid = complete_c && (d_owner == OWN_LS);
    if_err    = if_rvalid && HRESP;
    ls_err    = ls_rvalid && HRESP;
    if_rdata  = HRDATA;
    ls_rdata  = HRDATA;
  end

endmodule

// File: tb/tb_riscv_core_ahb_arbiter.sv
// Testbench for riscv_core_ahb_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbiter.
module tb_riscv_core_ahb_arbiter;

  localparam int unsigned MAX_STARVE = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic [31:0] ls_addr = '0;
  logic        ls_write = 1'b0;
  logic [2:0]  ls_size = 3'b010;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  int errors = 0;
  int checks = 0;

  riscv_core_ahb_arbiter #(.MAX_STARVE(MAX_STARVE)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_write(ls_write), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 CLK = ~CLK;

  // Inputs change just after the rising edge; outputs are checked at the falling edge
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      if_req = 1'b0; ls_req = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; if_req = 1'b1; ls_req = 1'b1; HREADY = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans got=%0h exp=0", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr got=%0h exp=0", HADDR); end
    checks++; if (HWRITE !== 1'b0) begin errors++; $display("FAIL reset_hwrite got=%0h exp=0", HWRITE); end
    checks++; if (HSIZE !== 3'b000) begin errors++; $display("FAIL reset_hsize got=%0h exp=0", HSIZE); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata got=%0h exp=0", HWDATA); end
    checks++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%0b%0b exp=00", if_gnt, ls_gnt); end
    checks++; if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%0b%0b exp=00", if_rvalid, ls_rvalid); end
    next_cycle();
    RST = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    @(negedge CLK);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL release_htrans got=%0h exp=0", HTRANS); end
  endtask

  task automatic test_if_read();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h100; HREADY = 1'b1;
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin errors++; $display("FAIL ifrd_gnt got=%0b%0b exp=10", if_gnt, ls_gnt); end
    next_cycle();
    if_req = 1'b0;
    @(negedge CLK);
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL ifrd_htrans got=%0h exp=2", HTRANS); end
    checks++; if (HADDR !== 32'h100) begin errors++; $display("FAIL ifrd_haddr got=%0h exp=100", HADDR); end
    checks++; if (HSIZE !== 3'b010 || HWRITE !== 1'b0) begin errors++; $display("FAIL ifrd_attr got=%0h/%0b exp=2/0", HSIZE, HWRITE); end
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL ifrd_early_rvalid got=%0b exp=0", if_rvalid); end
    next_cycle();
    HRDATA = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0) begin errors++; $display("FAIL ifrd_rvalid got=%0b%0b exp=10", if_rvalid, ls_rvalid); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_rdata got=%0h exp=deadbeef", if_rdata); end
    checks++; if (if_err !== 1'b0) begin errors++; $display("FAIL ifrd_err got=%0b exp=0", if_err); end
    idle(2);
  endtask

  task automatic test_starvation();
    string exp_order;
    byte   got;
    exp_order = "LLLLILLLLI";
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if_req = 1'b1; if_addr = 32'h1000 + 32'(i * 4);
      ls_req = 1'b1; ls_addr = 32'h8000 + 32'(i * 4); ls_write = 1'b0; ls_size = 3'b010;
      HREADY = 1'b1;
      @(negedge CLK);
      got = ls_gnt ? "L" : (if_gnt ? "I" : "-");
      checks++; if (got !== exp_order[i] || (if_gnt && ls_gnt)) begin errors++; $display("FAIL starve_order[%0d] got=%s exp=%s", i, got, exp_order[i]); end
    end
    idle(3);
  endtask

  task automatic test_wait_states();
    next_cycle();
    ls_req = 1'b1; ls_addr = 32'h2000; ls_write = 1'b1; ls_size = 3'b010; ls_wdata = 32'h55AA;
    @(negedge CLK);
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL ws_store_gnt got=%0b exp=1", ls_gnt); end
    next_cycle();
    ls_addr = 32'h3000; ls_write = 1'b0; ls_wdata = 32'h0;
    @(negedge CLK);
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL ws_read_gnt got=%0b exp=1", ls_gnt); end
    checks++; if (HWRITE !== 1'b1 || HADDR !== 32'h2000) begin errors++; $display("FAIL ws_store_addr got=%0h/%0b exp=2000/1", HADDR, HWRITE); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      ls_req = 1'b0;
      HREADY = (i == 2);
      @(negedge CLK);
      checks++; if (HWDATA !== 32'h55AA) begin errors++; $display("FAIL ws_hwdata[%0d] got=%0h exp=55aa", i, HWDATA); end
      checks++; if (HADDR !== 32'h3000 || HTRANS !== 2'b10) begin errors++; $display("FAIL ws_read_addr[%0d] got=%0h/%0h exp=3000/2", i, HADDR, HTRANS); end
      checks++; if (ls_rvalid !== (i == 2)) begin errors++; $display("FAIL ws_rvalid[%0d] got=%0b exp=%0b", i, ls_rvalid, (i == 2)); end
      checks++; if (ls_gnt !== 1'b0) begin errors++; $display("FAIL ws_gnt[%0d] got=%0b exp=0", i, ls_gnt); end
    end
    next_cycle();
    HREADY = 1'b1; HRDATA = 32'hCAFE0001;
    @(negedge CLK);
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL ws_read_done got=%0b/%0h exp=1/cafe0001", ls_rvalid, ls_rdata); end
    checks++; if (HWDATA !== 32'h0 || HTRANS !== 2'b00) begin errors++; $display("FAIL ws_tail got=%0h/%0h exp=0/0", HWDATA, HTRANS); end
    idle(2);
  endtask

  task automatic test_error();
    next_cycle();
    ls_req = 1'b1; ls_addr = 32'h400; ls_write = 1'b0; ls_size = 3'b010;
    @(negedge CLK);
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL err_ls_gnt got=%0b exp=1", ls_gnt); end
    next_cycle();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL err_if_gnt got=%0b exp=1", if_gnt); end
    next_cycle();
    if_req = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
    @(negedge CLK);
    checks++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL err_first_cycle got=%0b%0b exp=00", ls_rvalid, if_rvalid); end
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h500) begin errors++; $display("FAIL err_pending_a got=%0h/%0h exp=2/500", HTRANS, HADDR); end
    next_cycle();
    HREADY = 1'b1; HRESP = 1'b1;
    @(negedge CLK);
    checks++; if (ls_rvalid !== 1'b1 || ls_err !== 1'b1) begin errors++; $display("FAIL err_second_cycle got=%0b/%0b exp=1/1", ls_rvalid, ls_err); end
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL err_if_quiet got=%0b exp=0", if_rvalid); end
    next_cycle();
    HRESP = 1'b0; HRDATA = 32'h12345678;
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h12345678) begin errors++; $display("FAIL err_if_done got=%0b/%0b/%0h exp=1/0/12345678", if_rvalid, if_err, if_rdata); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    string exp_order;
    byte   got;
    exp_order = "LLLLI";
    // Three LS wins while IF waits raise the starvation count to 3
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if_req = 1'b1; if_addr = 32'h600; ls_req = 1'b1; ls_addr = 32'h700; ls_write = 1'b0;
    end
    next_cycle();
    if_req = 1'b0; ls_req = 1'b0; HREADY = 1'b0; RST = 1'b0;
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin errors++; $display("FAIL rmid_gnt got=%0b%0b exp=00", if_gnt, ls_gnt); end
    next_cycle();
    RST = 1'b1; HREADY = 1'b1;
    @(negedge CLK);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rmid_htrans got=%0h exp=0", HTRANS); end
    checks++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid got=%0b%0b exp=00", ls_rvalid, if_rvalid); end
    // A cleared counter means four LS wins again before IF
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if_req = 1'b1; if_addr = 32'h900; ls_req = 1'b1; ls_addr = 32'hA00;
      @(negedge CLK);
      got = ls_gnt ? "L" : (if_gnt ? "I" : "-");
      checks++; if (got !== exp_order[i]) begin errors++; $display("FAIL rmid_order[%0d] got=%s exp=%s", i, got, exp_order[i]); end
    end
    next_cycle();
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge CLK);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h900) begin errors++; $display("FAIL rmid_if_addr got=%0h/%0h exp=2/900", HTRANS, HADDR); end
    next_cycle();
    HRDATA = 32'h0BADF00D;
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rmid_if_done got=%0b/%0h exp=1/badf00d", if_rvalid, if_rdata); end
    idle(2);
  endtask

  // Transaction-level reference: one transfer in address phase, one in data phase
  typedef struct {
    bit          own;    // 0 = IF, 1 = LS
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  task automatic test_random();
    txn_t aq[$];
    txn_t dq[$];
    txn_t t;
    bit   order_q[$];
    int   starve;
    bit   m_if, m_ls, can, err_pend, exp_ifv, exp_lsv, own;
    logic [31:0] exp_wd;

    next_cycle();
    RST = 1'b0; if_req = 1'b0; ls_req = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    starve = 0; m_if = 1'b0; m_ls = 1'b0; err_pend = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      next_cycle();
      RST = 1'b1;
      if (m_if || !if_req) begin
        if_req = ($urandom % 2) == 0;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (($urandom % 16) == 0) begin
        if_req = 1'b0;
      end
      if (m_ls || !ls_req) begin
        ls_req = ($urandom % 4) != 0;
        ls_addr = $urandom;
        ls_write = $urandom % 2;
        ls_size = 3'($urandom % 3);
        ls_wdata = $urandom;
      end else if (($urandom % 16) == 0) begin
        ls_req = 1'b0;
      end
      HRDATA = $urandom;
      if (err_pend) begin
        HREADY = 1'b1; HRESP = 1'b1; err_pend = 1'b0;
      end else if (dq.size() != 0 && ($urandom % 10) == 0) begin
        HREADY = 1'b0; HRESP = 1'b1; err_pend = 1'b1;
      end else begin
        HREADY = ($urandom % 4) != 0; HRESP = 1'b0;
      end

      @(negedge CLK);
      can  = (aq.size() == 0) || HREADY;
      m_ls = can && ls_req && (!if_req || starve < int'(MAX_STARVE));
      m_if = can && if_req && !m_ls;
      exp_ifv = dq.size() != 0 && HREADY && !dq[0].own;
      exp_lsv = dq.size() != 0 && HREADY && dq[0].own;
      exp_wd  = (dq.size() != 0 && dq[0].wr) ? dq[0].wdata : 32'h0;

      checks++; if (if_gnt !== m_if || ls_gnt !== m_ls) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%0b%0b exp=%0b%0b", cyc, if_gnt, ls_gnt, m_if, m_ls); end
      checks++; if (HTRANS !== ((aq.size() != 0) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL rnd_htrans cyc=%0d got=%0h exp=%0h", cyc, HTRANS, (aq.size() != 0) ? 2 : 0); end
      if (aq.size() != 0) begin
        checks++; if (HADDR !== aq[0].addr || HWRITE !== aq[0].wr || HSIZE !== aq[0].size) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%0h/%0b/%0h exp=%0h/%0b/%0h", cyc, HADDR, HWRITE, HSIZE, aq[0].addr, aq[0].wr, aq[0].size); end
      end
      checks++; if (HWDATA !== exp_wd) begin errors++; $display("FAIL rnd_hwdata cyc=%0d got=%0h exp=%0h", cyc, HWDATA, exp_wd); end
      checks++; if (if_rvalid !== exp_ifv || ls_rvalid !== exp_lsv) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%0b%0b exp=%0b%0b", cyc, if_rvalid, ls_rvalid, exp_ifv, exp_lsv); end
      checks++; if (if_err !== (exp_ifv && HRESP) || ls_err !== (exp_lsv && HRESP)) begin errors++; $display("FAIL rnd_err cyc=%0d got=%0b%0b exp=%0b%0b", cyc, if_err, ls_err, exp_ifv && HRESP, exp_lsv && HRESP); end
      checks++; if (if_rdata !== HRDATA || ls_rdata !== HRDATA) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%0h/%0h exp=%0h", cyc, if_rdata, ls_rdata, HRDATA); end

      // Completions must come back in grant order
      if (if_rvalid || ls_rvalid) begin
        checks++;
        if (order_q.size() == 0) begin
          errors++; $display("FAIL rnd_order cyc=%0d got=completion exp=none_outstanding", cyc);
        end else begin
          own = order_q.pop_front();
          if (own !== ls_rvalid) begin errors++; $display("FAIL rnd_order cyc=%0d got=%0b exp=%0b", cyc, ls_rvalid, own); end
        end
      end

      if (HREADY) begin
        dq.delete();
        if (aq.size() != 0) dq.push_back(aq[0]);
      end
      if (can) begin
        aq.delete();
        if (m_ls) begin
          t.own = 1'b1; t.addr = ls_addr; t.wr = ls_write; t.size = ls_size; t.wdata = ls_wdata;
          aq.push_back(t); order_q.push_back(1'b1);
        end else if (m_if) begin
          t.own = 1'b0; t.addr = if_addr; t.wr = 1'b0; t.size = 3'b010; t.wdata = 32'h0;
          aq.push_back(t); order_q.push_back(1'b0);
        end
      end
      if (m_if || !if_req) starve = 0;
      else if (m_ls && starve < int'(MAX_STARVE)) starve++;
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_starvation();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_core_ahb_arbiter.md
# riscv_core_ahb_arbiter

Two-requester arbiter sharing one AHB-Lite master port between the fetch unit (IF) and the memory stage load/store unit (LS). It registers the winning request into an address-phase slot, tracks the outstanding data phase, and routes HRDATA/HREADY/HRESP back to the correct owner. LS has fixed priority, bounded by a fetch anti-starvation counter. It sits between the core pipeline and the single AHB-Lite system bus.

## Interface
- MAX_STARVE, 4, consecutive LS grants allowed while IF requests before IF is forced to win; 1..15
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-low
- if_req  in  1  IF request; held with if_addr until if_gnt
- if_addr  in  32  IF word address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF data phase completes this cycle
- if_rdata  out  32  HRDATA passthrough
- if_err  out  1  IF transfer ended in error (qualifies if_rvalid)
- ls_req  in  1  LS request; held with attributes until ls_gnt
- ls_addr  in  32  LS byte address
- ls_write  in  1  1 = store
- ls_size  in  3  HSIZE encoding (0 byte, 1 half, 2 word)
- ls_wdata  in  32  store data, sampled with ls_gnt
- ls_gnt, ls_rvalid, ls_err  out  1  as IF equivalents
- ls_rdata  out  32  HRDATA passthrough
- HADDR  out  32  registered address
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only
- HWRITE  out  1  registered
- HSIZE  out  3  registered; IF always 3'b010
- HWDATA  out  32  data-phase write data, registered
- HRDATA  in  32  read data
- HREADY  in  1  transfer ready
- HRESP  in  1  error response

## Operation
- Address slot (A): valid, owner, addr, write, size, wdata. Data slot (D): valid, owner, write, wdata.
- Slot A may load when A empty or HREADY=1 ("advance"). Combinational in that cycle: winner chosen, its gnt=1; otherwise both gnt=0.
- Arbitration: if both request and starve counter < MAX_STARVE -> LS; if counter = MAX_STARVE -> IF; single requester wins.
- Starve counter: +1 on each LS grant while if_req=1; cleared on IF grant or when if_req=0; saturates at MAX_STARVE.
- On advance edge: D <= A (valid, owner, write, wdata); A <= winner or invalid. When A not advancing (HREADY=0 with A valid), A and all H* outputs hold.
- HTRANS = NONSEQ when A.valid else IDLE; HADDR/HWRITE/HSIZE from A; HWDATA from D.wdata (0 when D invalid or read).
- Completion: when D.valid and HREADY=1, owner's rvalid=1, err=HRESP; D clears unless reloaded. Other requester's rvalid=0.
- Error: first cycle (HRESP=1, HREADY=0) produces no rvalid; second cycle (HRESP=1, HREADY=1) produces rvalid+err. Pending A is not cancelled.
- rdata on both ports = HRDATA always; valid only with rvalid and !write.
- No same-cycle IF and LS gnt; at most one transfer in A and one in D.

## Timing
- Reset (RST=0 at edge): A, D invalid; HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0; counter 0; gnt/rvalid/err 0 (gnt forced 0 while RST=0). Mid-transfer reset abandons transfers; no rvalid follows.
- Idle bus, req in cycle 0: gnt cycle 0, NONSEQ cycle 1, rvalid cycle 2 (HREADY=1 throughout).
- Back-to-back with HREADY=1: one gnt per cycle, one rvalid per cycle, 2-cycle latency.
- Each HREADY=0 cycle delays both A advance and D completion by one cycle; gnt suppressed while A is valid and HREADY=0.
- Requester dropping req before gnt: no transfer issued (permitted; not an error).

## Test plan
- Reset then IF read 0x100, HREADY=1, HRDATA=0xDEADBEEF: if_gnt cycle 0, HADDR=0x100 NONSEQ cycle 1, if_rvalid with rdata 0xDEADBEEF cycle 2, err=0.
- Both requesting continuously, MAX_STARVE=4: grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- LS store 0x2000, wdata 0x55AA, size 2, then read, HREADY low 2 cycles in store data phase: HWDATA=0x55AA held 3 cycles, read HADDR held, ls_rvalid only on HREADY=1 cycles.
- LS read with HRESP error sequence: no rvalid in first error cycle; ls_rvalid=1, ls_err=1 in second; next queued IF transfer still completes normally.
- Reset asserted while transfer in D with HREADY=0: next cycle HTRANS=IDLE, no rvalid, counter 0; new IF request after release granted normally.
